// File: rtl/memory_loader_pkg.sv
// memory_loader_pkg
// Shared definitions for the framed-stream memory loader: FSM state
// encoding, the frame SYNC byte and the TARGET codes that select RAM or
// register bank.
package memory_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TARGET,
    ADDR,
    COUNT,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] TGT_RAM   = 8'h00;
  localparam logic [7:0] TGT_REG   = 8'h01;

endpackage

// File: rtl/memory_loader.sv
// memory_loader
// Receives a framed byte stream over a valid/ready handshake and writes the
// payload into the RAM or the register bank, replacing a simulation-time
// preload. Frame: SYNC, TARGET, ADDR, COUNT, COUNT data bytes, CHK, where the
// byte sum of everything after SYNC (CHK included) must be zero.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_data, in_valid   stream byte and its valid
//   in_ready            loader can accept a byte this cycle
//   ram_we, reg_we      one-cycle write strobes, one cycle after a data accept
//   wr_addr, wr_data    write address/data, held between strobes
//   cpu_hold            high while a frame is in progress
//   done, err           sticky result of the last frame
module memory_loader
  import memory_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  ram_we,
  output logic                  reg_we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

  state_t                state;
  logic                  tgt_reg;    // 1 selects the register bank
  logic [ADDR_WIDTH-1:0] ptr;
  logic [DATA_WIDTH-1:0] remaining;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] sum_next;
  logic                  accept;

  // DONE and ERROR are single report cycles; the stream is paused there so
  // the byte following a frame is never swallowed by the report.
  assign in_ready = (state != DONE) && (state != ERROR);
  assign accept   = in_valid && in_ready;
  assign sum_next = sum + in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tgt_reg   <= 1'b0;
      ptr       <= '0;
      remaining <= '0;
      sum       <= '0;
      ram_we    <= 1'b0;
      reg_we    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      reg_we <= 1'b0;
      case (state)
        IDLE: begin
          // Non-SYNC bytes are consumed and dropped to resynchronise.
          if (accept && (in_data == DATA_WIDTH'(SYNC_BYTE))) begin
            state    <= TARGET;
            done     <= 1'b0;
            err      <= 1'b0;
            sum      <= '0;
            cpu_hold <= 1'b1;
          end
        end
        TARGET: begin
          if (accept) begin
            if (in_data > DATA_WIDTH'(TGT_REG)) begin
              state <= ERROR;
            end else begin
              tgt_reg <= (in_data == DATA_WIDTH'(TGT_REG));
              sum     <= sum_next;
              state   <= ADDR;
            end
          end
        end
        ADDR: begin
          if (accept) begin
            ptr   <= in_data[ADDR_WIDTH-1:0];
            sum   <= sum_next;
            state <= COUNT;
          end
        end
        COUNT: begin
          if (accept) begin
            remaining <= in_data;
            sum       <= sum_next;
            state     <= (in_data == '0) ? CHECK : DATA;
          end
        end
        DATA: begin
          if (accept) begin
            wr_data   <= in_data;
            wr_addr   <= ptr;
            ram_we    <= ~tgt_reg;
            reg_we    <= tgt_reg;
            ptr       <= ptr + 1'b1;  // wraps modulo depth
            remaining <= remaining - 1'b1;
            sum       <= sum_next;
            if (remaining == DATA_WIDTH'(1)) state <= CHECK;
          end
        end
        CHECK: begin
          if (accept) begin
            sum   <= sum_next;
            state <= (sum_next == '0) ? DONE : ERROR;
          end
        end
        DONE: begin
          done     <= 1'b1;
          cpu_hold <= 1'b0;
          state    <= IDLE;
        end
        ERROR: begin
          err      <= 1'b1;
          cpu_hold <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
